// File: rtl/if_fetch_stage_if.sv
// Bundle between the fetch stage, the instruction ROM and the hazard/EX logic.
// master = fetch stage, slave = the surrounding pipeline and ROM.
interface if_fetch_stage_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic                  stall;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic [31:0]           pc;
  logic [31:0]           if_id_pc;
  logic [DATA_WIDTH-1:0] if_id_instr;
  logic                  if_id_valid;
  logic                  halted;
  logic [31:0]           fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_data,
    output imem_addr, pc, if_id_pc, if_id_instr, if_id_valid, halted, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_data,
    input  imem_addr, pc, if_id_pc, if_id_instr, if_id_valid, halted, fetch_count
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// fills the IF/ID register; handles stall, EX redirect and EBREAK halt.
//
// state  | meaning
// BOOT   | one cycle after reset, PC held, bubble issued
// RUN    | normal fetch, honours redirect > stall > fetch
// HALTED | EBREAK issued, bubbles until a redirect arrives
module if_fetch_stage #(
  parameter int          ADDR_WIDTH = 7,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  if_fetch_stage_if.master  fetch_io
);

  localparam logic [DATA_WIDTH-1:0] NOP    = DATA_WIDTH'(32'h0000_0013);
  localparam logic [DATA_WIDTH-1:0] EBREAK = DATA_WIDTH'(32'h0010_0073);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           if_id_pc_q, if_id_pc_d;
  logic [DATA_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
  logic                  if_id_valid_q, if_id_valid_d;
  logic [31:0]           fetch_count_q, fetch_count_d;
  logic                  bubble;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    bubble        = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        bubble  = 1'b1;
      end
      RUN: begin
        if (fetch_io.redirect_valid) begin
          pc_d   = fetch_io.redirect_pc & ~32'h3;
          bubble = 1'b1;
        end else if (!fetch_io.stall) begin
          if_id_instr_d = fetch_io.imem_data;
          if_id_pc_d    = pc_q;
          if_id_valid_d = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
          // EBREAK is issued but the PC parks on it
          if (fetch_io.imem_data == EBREAK) state_d = HALTED;
          else                              pc_d    = pc_q + 32'd4;
        end
      end
      HALTED: begin
        bubble = 1'b1;
        if (fetch_io.redirect_valid) begin
          state_d = RUN;
          pc_d    = fetch_io.redirect_pc & ~32'h3;
        end
      end
      default: begin
        state_d = BOOT;
        bubble  = 1'b1;
      end
    endcase

    if (bubble) begin
      if_id_pc_d    = '0;
      if_id_instr_d = NOP;
      if_id_valid_d = 1'b0;
    end
  end

  assign fetch_io.imem_addr   = pc_q[ADDR_WIDTH+1:2];
  assign fetch_io.pc          = pc_q;
  assign fetch_io.if_id_pc    = if_id_pc_q;
  assign fetch_io.if_id_instr = if_id_instr_q;
  assign fetch_io.if_id_valid = if_id_valid_q;
  assign fetch_io.halted      = (state_q == HALTED);
  assign fetch_io.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: boot, stall, redirect, EBREAK halt,
// reset while halted, and PC wrap/alias on a second instance.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [31:0] rom0 [128];
  logic [31:0] rom1 [128];

  if_fetch_stage_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) bus0 ();
  if_fetch_stage_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) bus1 ();

  assign bus0.imem_data = rom0[bus0.imem_addr];
  assign bus1.imem_data = rom1[bus1.imem_addr];

  if_fetch_stage #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .RESET_PC(32'h0)) u_dut0 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .fetch_io (bus0)
  );

  if_fetch_stage #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .RESET_PC(32'h1FC)) u_dut1 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .fetch_io (bus1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, return on the falling edge to sample and drive
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, ".pc"},    bus0.pc,          32'h0);
    chk({tag, ".idpc"},  bus0.if_id_pc,    32'h0);
    chk({tag, ".instr"}, bus0.if_id_instr, NOP);
    chk({tag, ".valid"}, 32'(bus0.if_id_valid), 32'd0);
    chk({tag, ".halt"},  32'(bus0.halted),      32'd0);
    chk({tag, ".cnt"},   bus0.fetch_count, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      rom0[i] = 32'h1000_0000 + 32'(i);
      rom1[i] = 32'h2000_0000 + 32'(i);
    end
    rom0[0] = 32'h0050_0093;
    rom0[1] = 32'h0010_0113;
    rom0[2] = 32'h0020_81B3;
    rom0[3] = 32'h0000_0013;
    rom1[127] = 32'hDEAD_007F;
    rom1[0]   = 32'h1111_0000;

    bus0.stall = 1'b0; bus0.redirect_valid = 1'b0; bus0.redirect_pc = '0;
    bus1.stall = 1'b0; bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0;

    // reset
    tick(); tick();
    chk_reset0("rst");
    chk("rst1.pc", bus1.pc, 32'h1FC);
    rst_i = 1'b0;

    // BOOT edge: bubble, pc held
    tick();
    chk("boot.valid", 32'(bus0.if_id_valid), 32'd0);
    chk("boot.pc",    bus0.pc, 32'h0);
    chk("boot1.addr", 32'(bus1.imem_addr), 32'd127);

    // first fetch
    tick();
    chk("f0.valid", 32'(bus0.if_id_valid), 32'd1);
    chk("f0.idpc",  bus0.if_id_pc, 32'h0);
    chk("f0.instr", bus0.if_id_instr, 32'h0050_0093);
    chk("f0.pc",    bus0.pc, 32'h4);
    chk("wrap.instr", bus1.if_id_instr, 32'hDEAD_007F);
    chk("wrap.idpc",  bus1.if_id_pc, 32'h1FC);
    chk("wrap.pc",    bus1.pc, 32'h200);
    chk("wrap.addr",  32'(bus1.imem_addr), 32'd0);

    tick();
    chk("f1.idpc",  bus0.if_id_pc, 32'h4);
    chk("f1.instr", bus0.if_id_instr, 32'h0010_0113);
    chk("f1.pc",    bus0.pc, 32'h8);
    chk("wrap2.instr", bus1.if_id_instr, 32'h1111_0000);

    // stall 3 cycles at pc=8
    bus0.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall.idpc",  bus0.if_id_pc, 32'h4);
      chk("stall.pc",    bus0.pc, 32'h8);
      chk("stall.cnt",   bus0.fetch_count, 32'd2);
    end
    bus0.stall = 1'b0;

    tick();
    chk("rel.idpc",  bus0.if_id_pc, 32'h8);
    chk("rel.instr", bus0.if_id_instr, 32'h0020_81B3);
    chk("rel.pc",    bus0.pc, 32'hC);

    tick();
    chk("f3.idpc", bus0.if_id_pc, 32'hC);
    chk("f3.cnt",  bus0.fetch_count, 32'd4);
    chk("f3.pc",   bus0.pc, 32'h10);

    // redirect overrides stall
    bus0.stall = 1'b1; bus0.redirect_valid = 1'b1; bus0.redirect_pc = 32'h20;
    tick();
    chk("rd.pc",    bus0.pc, 32'h20);
    chk("rd.valid", 32'(bus0.if_id_valid), 32'd0);
    chk("rd.instr", bus0.if_id_instr, NOP);
    chk("rd.idpc",  bus0.if_id_pc, 32'h0);
    chk("rd.cnt",   bus0.fetch_count, 32'd4);
    bus0.stall = 1'b0; bus0.redirect_valid = 1'b0;

    tick();
    chk("rt.idpc",  bus0.if_id_pc, 32'h20);
    chk("rt.instr", bus0.if_id_instr, 32'h1000_0008);
    chk("rt.valid", 32'(bus0.if_id_valid), 32'd1);
    chk("rt.cnt",   bus0.fetch_count, 32'd5);

    // misaligned redirect target is truncated
    bus0.redirect_valid = 1'b1; bus0.redirect_pc = 32'h23;
    tick();
    chk("mis.pc",   bus0.pc, 32'h20);
    chk("mis.addr", 32'(bus0.imem_addr), 32'd8);
    bus0.redirect_valid = 1'b0;

    // EBREAK at word 2
    rom0[2] = EBREAK;
    rst_i = 1'b1;
    tick();
    chk_reset0("rst2");
    rst_i = 1'b0;
    tick(); tick(); tick();
    chk("pre.pc", bus0.pc, 32'h8);
    tick();
    chk("eb.valid", 32'(bus0.if_id_valid), 32'd1);
    chk("eb.idpc",  bus0.if_id_pc, 32'h8);
    chk("eb.instr", bus0.if_id_instr, EBREAK);
    chk("eb.halt",  32'(bus0.halted), 32'd1);
    chk("eb.pc",    bus0.pc, 32'h8);
    chk("eb.cnt",   bus0.fetch_count, 32'd3);

    bus0.stall = 1'b1;
    tick();
    chk("hlt.valid", 32'(bus0.if_id_valid), 32'd0);
    chk("hlt.instr", bus0.if_id_instr, NOP);
    chk("hlt.pc",    bus0.pc, 32'h8);
    chk("hlt.cnt",   bus0.fetch_count, 32'd3);
    chk("hlt.halt",  32'(bus0.halted), 32'd1);
    bus0.stall = 1'b0;

    // redirect out of HALTED
    bus0.redirect_valid = 1'b1; bus0.redirect_pc = 32'h0;
    tick();
    chk("res.halt",  32'(bus0.halted), 32'd0);
    chk("res.pc",    bus0.pc, 32'h0);
    chk("res.valid", 32'(bus0.if_id_valid), 32'd0);
    bus0.redirect_valid = 1'b0;
    tick();
    chk("res2.valid", 32'(bus0.if_id_valid), 32'd1);
    chk("res2.idpc",  bus0.if_id_pc, 32'h0);
    chk("res2.cnt",   bus0.fetch_count, 32'd4);

    // run to EBREAK again, then reset while halted
    tick(); tick();
    chk("eb2.halt", 32'(bus0.halted), 32'd1);
    chk("eb2.cnt",  bus0.fetch_count, 32'd6);
    bus0.stall = 1'b1;
    rst_i = 1'b1;
    tick();
    chk_reset0("rsth");
    bus0.stall = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
